block_mult_scheduler: RTL and testbench

//  Sequences one 2x2-block matrix product C = A x B, where each matrix holds N_BLK x N_BLK blocks.
//  For every output block (i,j), it clears the block accumulator, then for k = 0..N_BLK-1:
//    - starts the 2x2 block multiplier on A(i,k) x B(k,j);
//    - starts the accumulator on the resulting partial product.

---
 rtl/block_mult_scheduler_if.sv | 36 +++
 rtl/block_mult_scheduler.sv | 178 +++++++++++++++++
 tb/tb_block_mult_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_mult_scheduler_if.sv
// Control bundle between the block-product scheduler and its neighbours.
// Latency: none, wires only.
// Backpressure: write-back stalls the scheduler through wr_ready.
interface block_mult_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] blk_i;
  logic [IDX_W-1:0] blk_j;
  logic [IDX_W-1:0] blk_k;
  logic             mul_start;
  logic             mul_done;
  logic             acc_start;
  logic             acc_reset;
  logic             acc_done;
  logic             wr_valid;
  logic             wr_ready;

  // Scheduler side.
  modport master (
    input  start, abort, mul_done, acc_done, wr_ready,
    output busy, done, error, blk_i, blk_j, blk_k,
           mul_start, acc_start, acc_reset, wr_valid
  );

  // Control / datapath side.
  modport slave (
    output start, abort, mul_done, acc_done, wr_ready,
    input  busy, done, error, blk_i, blk_j, blk_k,
           mul_start, acc_start, acc_reset, wr_valid
  );
endinterface

// File: rtl/block_mult_scheduler.sv
// Sequences C = A x B over N_BLK x N_BLK 2x2 blocks: i outer, j middle, k inner.
// Latency: all outputs registered; one cycle from a state decision to its pulse.
// Backpressure: holds wr_valid with stable blk_i/blk_j until wr_ready; no new multiply meanwhile.
module block_mult_scheduler #(
  parameter int N_BLK   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  block_mult_scheduler_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_CLRW, S_MUL, S_MULW, S_ACC,
    S_ACCW, S_HOLD, S_WR, S_DONE, S_ERR
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BLK - 1);
  // Final wait cycle: the awaited done is still honoured here before erroring.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [IDX_W-1:0]   i_q, i_nxt;
  logic [IDX_W-1:0]   j_q, j_nxt;
  logic [IDX_W-1:0]   k_q, k_nxt;
  logic               err_q, err_nxt;

  logic               busy_q, done_q, mul_start_q, acc_start_q, acc_reset_q, wr_valid_q;

  // Next-state, index, timeout and error-flag decisions; abort overrides everything.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    k_nxt     = k_q;
    err_nxt   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_CLR;
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
          err_nxt   = 1'b0;
        end
      end
      S_CLR: begin
        k_nxt     = '0;
        state_nxt = S_CLRW;
      end
      S_CLRW: state_nxt = S_MUL;
      S_MUL: begin
        cnt_nxt   = '0;
        state_nxt = S_MULW;
      end
      S_MULW: begin
        if (bus.mul_done) begin
          state_nxt = S_ACC;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_ACC: begin
        cnt_nxt   = '0;
        state_nxt = S_ACCW;
      end
      S_ACCW: begin
        if (bus.acc_done) begin
          state_nxt = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (k_q == LAST_IDX) begin
          state_nxt = S_WR;
        end else begin
          k_nxt     = k_q + IDX_W'(1);
          state_nxt = S_MUL;
        end
      end
      S_WR: begin
        if (bus.wr_ready) begin
          if (i_q == LAST_IDX && j_q == LAST_IDX) begin
            state_nxt = S_DONE;
          end else if (j_q == LAST_IDX) begin
            j_nxt     = '0;
            i_nxt     = i_q + IDX_W'(1);
            state_nxt = S_CLR;
          end else begin
            j_nxt     = j_q + IDX_W'(1);
            state_nxt = S_CLR;
          end
        end
      end
      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        i_nxt     = '0;
        j_nxt     = '0;
        k_nxt     = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over every transition but leaves the error flag alone.
    if (bus.abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      i_nxt     = '0;
      j_nxt     = '0;
      k_nxt     = '0;
      err_nxt   = err_q;
    end
  end

  // State, indices, timeout counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      i_q     <= i_nxt;
      j_q     <= j_nxt;
      k_q     <= k_nxt;
      err_q   <= err_nxt;
    end
  end

  // Registered strobes decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      acc_start_q <= 1'b0;
      acc_reset_q <= 1'b0;
      wr_valid_q  <= 1'b0;
    end else begin
      busy_q      <= (state_nxt != S_IDLE);
      done_q      <= (state_nxt == S_DONE);
      mul_start_q <= (state_nxt == S_MUL);
      acc_start_q <= (state_nxt == S_ACC);
      wr_valid_q  <= (state_nxt == S_WR);
      // An abort mid-product leaves a partial sum behind, so scrub it once.
      acc_reset_q <= (state_nxt == S_CLR) || (state_nxt == S_ERR) ||
                     (bus.abort && state_q != S_IDLE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
  assign bus.blk_i     = i_q;
  assign bus.blk_j     = j_q;
  assign bus.blk_k     = k_q;
  assign bus.mul_start = mul_start_q;
  assign bus.acc_start = acc_start_q;
  assign bus.acc_reset = acc_reset_q;
  assign bus.wr_valid  = wr_valid_q;

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Directed bench for block_mult_scheduler with N_BLK=2, TIMEOUT=8.
// Multiplier/accumulator stubs answer 3 cycles after each start unless told otherwise.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_block_mult_scheduler;
  logic clk = 1'b0;
  logic reset_n;

  block_mult_scheduler_if #(.IDX_W(1)) bus ();

  block_mult_scheduler #(.N_BLK(2), .IDX_W(1), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // 0: answer after 3 cycles, 1: never answer, 2: tied high
  int mul_mode = 0;
  int mul_dly  = -1;
  int acc_dly  = -1;

  int n_mul, n_acc, n_rst, n_wr, n_done;
  int mul_sig, acc_sig, wr_sig;
  int last_mul_cyc, gap_bad, exp_gap, stall_bad;
  int done_cyc, err_cyc, first_rst_cyc, first_mul_cyc;
  logic       prev_wr_vld = 1'b0;
  logic [1:0] prev_ij     = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_mul = 0; n_acc = 0; n_rst = 0; n_wr = 0; n_done = 0;
    mul_sig = 0; acc_sig = 0; wr_sig = 0;
    last_mul_cyc = -100; gap_bad = 0; stall_bad = 0;
    done_cyc = -1; err_cyc = -1; first_rst_cyc = -1; first_mul_cyc = -1;
  endtask

  // One clock: record what the DUT shows this cycle, then update the stubs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_wr_vld && bus.wr_ready) begin
      n_wr++;
      wr_sig = (wr_sig << 2) | int'(prev_ij);
    end
    if (bus.mul_start) begin
      n_mul++;
      mul_sig = (mul_sig << 3) | int'({bus.blk_i, bus.blk_j, bus.blk_k});
      last_mul_cyc = cyc;
      if (first_mul_cyc < 0) first_mul_cyc = cyc;
    end
    if (bus.acc_start) begin
      n_acc++;
      acc_sig = (acc_sig << 3) | int'({bus.blk_i, bus.blk_j, bus.blk_k});
      if (cyc - last_mul_cyc != exp_gap) gap_bad++;
    end
    if (bus.acc_reset) begin
      n_rst++;
      if (first_rst_cyc < 0) first_rst_cyc = cyc;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.error && err_cyc < 0) err_cyc = cyc;
    prev_wr_vld = bus.wr_valid;
    prev_ij     = {bus.blk_i, bus.blk_j};

    if (bus.mul_start) mul_dly = 3;
    else if (mul_dly > 0) mul_dly--;
    else mul_dly = -1;
    if (bus.acc_start) acc_dly = 3;
    else if (acc_dly > 0) acc_dly--;
    else acc_dly = -1;
    case (mul_mode)
      0:       bus.mul_done = (mul_dly == 0);
      1:       bus.mul_done = 1'b0;
      default: bus.mul_done = 1'b1;
    endcase
    bus.acc_done = (acc_dly == 0);
  endtask

  // Full product; optional 10-cycle write stall at (0,1) and a stray start while busy.
  task automatic run_product(input string tag, input bit stall, input int busy_at,
                             input int exp_len, input int gap);
    int  s;
    bit  stalled;
    clear_stats();
    exp_gap = gap;
    stalled = 1'b0;
    bus.start = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (stall && !stalled && bus.wr_valid && bus.blk_i == 1'b0 && bus.blk_j == 1'b1) begin
        stalled = 1'b1;
        bus.wr_ready = 1'b0;
        for (int w = 0; w < 10; w++) begin
          tick();
          if (!(bus.wr_valid && bus.blk_i == 1'b0 && bus.blk_j == 1'b1 && !bus.mul_start))
            stall_bad++;
        end
        bus.wr_ready = 1'b1;
      end
      bus.start = (busy_at > 0 && cyc - s == busy_at);
      tick();
      if (n_done > 0 && !bus.busy) break;
    end
    bus.start = 1'b0;
    chk({tag, "_len"},       done_cyc - s,      exp_len);
    chk({tag, "_first_rst"}, first_rst_cyc - s, 1);
    chk({tag, "_first_mul"}, first_mul_cyc - s, 3);
    chk({tag, "_n_mul"},     n_mul,  8);
    chk({tag, "_n_acc"},     n_acc,  8);
    chk({tag, "_n_rst"},     n_rst,  4);
    chk({tag, "_n_wr"},      n_wr,   4);
    chk({tag, "_n_done"},    n_done, 1);
    chk({tag, "_mul_seq"},   mul_sig, 32'o01234567);
    chk({tag, "_acc_seq"},   acc_sig, 32'o01234567);
    chk({tag, "_wr_seq"},    wr_sig,  32'h1B);
    chk({tag, "_gap"},       gap_bad, 0);
    chk({tag, "_busy_end"},  bus.busy,  0);
    chk({tag, "_err_end"},   bus.error, 0);
    if (stall) chk({tag, "_stall"}, stall_bad + (stalled ? 0 : 100), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int n_rst0;
    int n_done0;
    logic [9:0] outs;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.wr_ready = 1'b1;
    bus.mul_done = 1'b0; bus.acc_done = 1'b0;
    clear_stats();
    #7;
    outs = {bus.busy, bus.done, bus.error, bus.mul_start, bus.acc_start,
            bus.acc_reset, bus.wr_valid, bus.blk_i, bus.blk_j, bus.blk_k};
    chk("reset_outs", outs, 0);
    #5;
    reset_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Plain product, 9 cycles per k, 21 per block.
    mul_mode = 0;
    run_product("basic", 1'b0, 0, 85, 4);

    // Write-back stall at (0,1).
    run_product("stall", 1'b1, 0, 95, 4);

    // mul_done stuck high: one MULW cycle per k.
    mul_mode = 2;
    run_product("tied", 1'b0, 0, 69, 2);

    // Multiplier never answers: timeout.
    mul_mode = 1;
    clear_stats();
    bus.start = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (err_cyc >= 0) break;
      tick();
    end
    chk("to_err_lat", err_cyc - s, 12);
    chk("to_err_rst", bus.acc_reset, 1);
    chk("to_n_mul", n_mul, 1);
    tick();
    chk("to_idle", bus.busy, 0);
    chk("to_n_rst", n_rst, 2);
    repeat (5) tick();
    chk("to_sticky", bus.error, 1);
    mul_mode = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("to_clear", bus.error, 0);

    // Abort while waiting on the accumulator at block (1,0).
    exp_gap = 4;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.acc_start && bus.blk_i == 1'b1 && bus.blk_j == 1'b0) break;
    end
    chk("ab_reach", {bus.acc_start, bus.blk_i, bus.blk_j}, 3'b110);
    tick();
    n_rst0 = n_rst;
    n_done0 = n_done;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_rst", bus.acc_reset, 1);
    chk("ab_idx", {bus.blk_i, bus.blk_j, bus.blk_k, bus.wr_valid}, 0);
    repeat (5) tick();
    chk("ab_rst_cnt", n_rst - n_rst0, 1);
    chk("ab_no_done", n_done - n_done0, 0);
    run_product("restart", 1'b0, 0, 85, 4);

    // Asynchronous reset while a block is offered to write-back.
    clear_stats();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.wr_valid) break;
      tick();
    end
    chk("rs_in_wr", bus.wr_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    outs = {bus.busy, bus.done, bus.error, bus.mul_start, bus.acc_start,
            bus.acc_reset, bus.wr_valid, bus.blk_i, bus.blk_j, bus.blk_k};
    chk("rs_async", outs, 0);
    tick();
    chk("rs_no_pulse", {bus.acc_reset, bus.busy}, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("rs_stay_idle", bus.busy, 0);

    // Stray start while busy must not disturb anything.
    run_product("rerun", 1'b0, 20, 85, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
